// File: rtl/uart_ctl_if.sv
// Simple ARM-side register bus between the AXI3 bridge and the UART controller.
// The master holds armreq (with address/data/direction) until it sees the
// one-cycle armack pulse; read data and the error flag are valid with armack.
interface uart_ctl_if;
    logic [31:0] armaddr;
    logic [31:0] armwdata;
    logic [3:0]  armwstrb;
    logic        armwr;
    logic        armreq;
    logic        armack;
    logic        armerr;
    logic [31:0] armrdata;

    modport master (
        output armaddr, armwdata, armwstrb, armwr, armreq,
        input  armack, armerr, armrdata
    );

    modport slave (
        input  armaddr, armwdata, armwstrb, armwr, armreq,
        output armack, armerr, armrdata
    );
endinterface

// File: rtl/uart_ctl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs behind a DATA/STATUS/CTRL
// register map, plus the transmit handshake sequencer towards the uart core.
// Register side effects (FIFO push/pop, CTRL updates) commit on the same edge
// that raises armack, so they are visible from the ack cycle onwards.
module uart_ctl #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_ctl_if.slave  bus,
    output logic       txreq,
    input  logic       txack,
    output logic [7:0] txdata,
    input  logic       rxreq,
    output logic       rxack,
    input  logic [7:0] rxdata
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // FIFO storage and pointers
    logic [7:0]       tx_mem_r [TX_DEPTH];
    logic [7:0]       rx_mem_r [RX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [RX_AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [TX_CW-1:0] tx_count_r;
    logic [RX_CW-1:0] rx_count_r;

    // Control/status state
    logic       overrun_r;
    logic       txen_r;
    tx_state_t  state_r, state_nxt_s;
    logic       txreq_r, txreq_nxt_s;
    logic [7:0] txdata_r;
    logic       rxack_r;
    logic       armack_r;
    logic       armerr_r;
    logic [31:0] armrdata_r;

    // Decoded events
    logic        bus_fire_s;
    logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic        rx_fire_s, ovr_set_s;
    logic        ctrl_wr_s, tx_flush_s, rx_flush_s, ovr_clr_s;
    logic [31:0] rdata_s;
    logic        err_s;
    logic [31:0] status_s;
    logic        unused_s;

    // Only address bits [3:2], data byte 0 and strobe 0 carry meaning.
    assign unused_s = &{1'b0, bus.armaddr[31:4], bus.armaddr[1:0],
                        bus.armwdata[31:8], bus.armwstrb[3:1]};

    assign tx_full_s  = (tx_count_r == TX_FULL_CNT);
    assign tx_empty_s = (tx_count_r == {TX_CW{1'b0}});
    assign rx_full_s  = (rx_count_r == RX_FULL_CNT);
    assign rx_empty_s = (rx_count_r == {RX_CW{1'b0}});

    // A request is taken only when no ack is in flight, giving one ack per request.
    assign bus_fire_s = bus.armreq && !armack_r;

    assign tx_flush_s = ctrl_wr_s && bus.armwdata[2];
    assign rx_flush_s = ctrl_wr_s && bus.armwdata[3];
    assign ovr_clr_s  = ctrl_wr_s && bus.armwdata[1];

    // A new byte is acknowledged every other cycle at most; a full FIFO still
    // accepts it if the bus pops in the same cycle, otherwise it is dropped.
    assign rx_fire_s = rxreq && !rxack_r;
    assign rx_push_s = rx_fire_s && (!rx_full_s || rx_pop_s);
    assign ovr_set_s = rx_fire_s && rx_full_s && !rx_pop_s;

    assign status_s = {8'h00, 8'(rx_count_r), 8'(tx_count_r), 3'b000,
                       overrun_r, rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};

    // TX sequencer next state: pop the head when enabled, hold until txack.
    always_comb begin
        state_nxt_s = state_r;
        txreq_nxt_s = txreq_r;
        tx_pop_s    = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (txen_r && !tx_empty_s) begin
                    tx_pop_s    = 1'b1;
                    txreq_nxt_s = 1'b1;
                    state_nxt_s = TX_SEND;
                end else begin
                    txreq_nxt_s = 1'b0;
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (txack) begin
                    txreq_nxt_s = 1'b0;
                    state_nxt_s = TX_IDLE;
                end else begin
                    txreq_nxt_s = 1'b1;
                    state_nxt_s = TX_SEND;
                end
            end
            default: begin
                txreq_nxt_s = 1'b0;
                state_nxt_s = TX_IDLE;
            end
        endcase
    end

    // Register decode: read data, error flag and side-effect strobes.
    always_comb begin
        rdata_s   = 32'h0000_0000;
        err_s     = 1'b0;
        tx_push_s = 1'b0;
        rx_pop_s  = 1'b0;
        ctrl_wr_s = 1'b0;
        if (bus_fire_s) begin
            case (bus.armaddr[3:2])
                2'd0: begin
                    if (bus.armwr) begin
                        if (bus.armwstrb[0]) begin
                            // Full FIFO still takes the byte if the sequencer pops now.
                            if (tx_full_s && !tx_pop_s) begin
                                err_s = 1'b1;
                            end else begin
                                tx_push_s = 1'b1;
                            end
                        end else begin
                            tx_push_s = 1'b0;
                        end
                    end else begin
                        if (rx_empty_s) begin
                            rdata_s = 32'h8000_0000;
                        end else begin
                            rdata_s  = {24'h00_0000, rx_mem_r[rx_rd_ptr_r]};
                            rx_pop_s = 1'b1;
                        end
                    end
                end
                2'd1: begin
                    if (!bus.armwr) begin
                        rdata_s = status_s;
                    end else begin
                        rdata_s = 32'h0000_0000;
                    end
                end
                2'd2: begin
                    if (bus.armwr) begin
                        ctrl_wr_s = bus.armwstrb[0];
                    end else begin
                        rdata_s = {31'h0000_0000, txen_r};
                    end
                end
                2'd3: begin
                    err_s = 1'b1;
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Bus response registers: armack pulse with its read data and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            armack_r   <= 1'b0;
            armerr_r   <= 1'b0;
            armrdata_r <= 32'h0000_0000;
        end else begin
            armack_r   <= bus_fire_s;
            armerr_r   <= err_s;
            armrdata_r <= rdata_s;
        end
    end

    // Control bits: transmit enable and sticky overrun (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            txen_r    <= 1'b1;
            overrun_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                txen_r <= bus.armwdata[0];
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // TX sequencer state, handshake and byte being sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= TX_IDLE;
            txreq_r  <= 1'b0;
            txdata_r <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            txreq_r <= txreq_nxt_s;
            if (tx_pop_s) begin
                txdata_r <= tx_mem_r[tx_rd_ptr_r];
            end
        end
    end

    // RX acknowledge pulse, issued for kept and dropped bytes alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxack_r <= 1'b0;
        end else begin
            rxack_r <= rx_fire_s;
        end
    end

    // TX FIFO pointers and count; a flush overrides any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || tx_flush_s) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            tx_count_r  <= '0;
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(1);
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + TX_AW'(1);
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + TX_CW'(1);
                2'b01:   tx_count_r <= tx_count_r - TX_CW'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX FIFO pointers and count; a flush overrides any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || rx_flush_s) begin
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            rx_count_r  <= '0;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(1);
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + RX_AW'(1);
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CW'(1);
                2'b01:   rx_count_r <= rx_count_r - RX_CW'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // FIFO storage writes; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= bus.armwdata[7:0];
        end
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= rxdata;
        end
    end

    assign bus.armack   = armack_r;
    assign bus.armerr   = armerr_r;
    assign bus.armrdata = armrdata_r;
    assign txreq        = txreq_r;
    assign txdata       = txdata_r;
    assign rxack        = rxack_r;

endmodule

// File: tb/tb_uart_ctl.sv
// Bench for uart_ctl: directed bus/uart stimulus, a queue-based reference
// model of the register map and FIFOs, and one per-cycle compare process.
module tb_uart_ctl;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       txreq, txack, rxreq, rxack;
    logic [7:0] txdata, rxdata;

    uart_ctl_if bus_if ();

    uart_ctl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .txreq  (txreq),
        .txack  (txack),
        .txdata (txdata),
        .rxreq  (rxreq),
        .rxack  (rxack),
        .rxdata (rxdata)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    bit          ov_m;
    bit          txen_m;
    logic [31:0] exp_rd_q[$];
    bit          exp_err_q[$];
    bit          tx_auto;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        ov_m   = 1'b0;
        txen_m = 1'b1;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = 32'h0;
        s[0]     = (tx_q.size() == TXD);
        s[1]     = (tx_q.size() == 0);
        s[2]     = (rx_q.size() == 0);
        s[3]     = (rx_q.size() == RXD);
        s[4]     = ov_m;
        s[15:8]  = 8'(tx_q.size());
        s[23:16] = 8'(rx_q.size());
        return s;
    endfunction

    task automatic model_bus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, output logic [31:0] rd, output bit err);
        rd  = 32'h0;
        err = 1'b0;
        case (addr[3:2])
            2'd0: begin
                if (wr) begin
                    if (strb[0]) begin
                        if (tx_q.size() >= TXD) err = 1'b1;
                        else tx_q.push_back(wdata[7:0]);
                    end
                end else if (rx_q.size() == 0) begin
                    rd = 32'h8000_0000;
                end else begin
                    rd = {24'h0, rx_q.pop_front()};
                end
            end
            2'd1: if (!wr) rd = model_status();
            2'd2: begin
                if (wr) begin
                    if (strb[0]) begin
                        txen_m = wdata[0];
                        if (wdata[1]) ov_m = 1'b0;
                        if (wdata[2]) tx_q.delete();
                        if (wdata[3]) rx_q.delete();
                    end
                end else begin
                    rd = {31'h0, txen_m};
                end
            end
            default: err = 1'b1;
        endcase
    endtask

    // One bus transfer: model expectation queued, ack latency checked here.
    task automatic bus_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] got_rd, output bit got_err);
        logic [31:0] erd;
        bit eerr;
        @(posedge clk); #1;
        model_bus(wr, addr, wdata, strb, erd, eerr);
        exp_rd_q.push_back(erd);
        exp_err_q.push_back(eerr);
        bus_if.armreq   = 1'b1;
        bus_if.armwr    = wr;
        bus_if.armaddr  = addr;
        bus_if.armwdata = wdata;
        bus_if.armwstrb = strb;
        @(negedge clk);
        check32("ack_early", {31'h0, bus_if.armack}, 32'h0);
        @(negedge clk);
        check32("ack_latency", {31'h0, bus_if.armack}, 32'h1);
        got_rd  = bus_if.armrdata;
        got_err = bus_if.armerr;
        if (!bus_if.armack && exp_rd_q.size() > 0) begin
            void'(exp_rd_q.pop_back());
            void'(exp_err_q.pop_back());
        end
        @(posedge clk); #1;
        bus_if.armreq = 1'b0;
        bus_if.armwr  = 1'b0;
    endtask

    // Raw uart receive handshake, checking the single-cycle rxack.
    task automatic rx_drive(input logic [7:0] b);
        @(posedge clk); #1;
        rxreq  = 1'b1;
        rxdata = b;
        @(negedge clk);
        check32("rxack_early", {31'h0, rxack}, 32'h0);
        @(negedge clk);
        check32("rxack", {31'h0, rxack}, 32'h1);
        @(posedge clk); #1;
        rxreq = 1'b0;
        @(negedge clk);
        check32("rxack_single", {31'h0, rxack}, 32'h0);
    endtask

    task automatic rx_send(input logic [7:0] b);
        if (rx_q.size() < RXD) rx_q.push_back(b);
        else ov_m = 1'b1;
        rx_drive(b);
    endtask

    // Uart transmitter stand-in: txack three cycles after txreq rises.
    initial begin : uart_tx
        int age;
        age   = 0;
        txack = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (txreq && tx_auto) begin
                age++;
                txack = (age == 3);
            end else begin
                age   = 0;
                txack = 1'b0;
            end
        end
    end

    // Per-cycle compare of bus responses and transmitted bytes against the model.
    initial begin : compare
        bit prev_txreq;
        logic [7:0] held;
        logic [7:0] b;
        prev_txreq = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_txreq = 1'b0;
            end else begin
                if (bus_if.armack) begin
                    if (exp_rd_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL spurious_ack: got armack=1 required 0 at %0t", $time);
                    end else begin
                        check32("rdata", bus_if.armrdata, exp_rd_q.pop_front());
                        check32("armerr", {31'h0, bus_if.armerr}, {31'h0, exp_err_q.pop_front()});
                    end
                end else begin
                    check32("rdata_idle", bus_if.armrdata, 32'h0);
                end
                if (txreq && !prev_txreq) begin
                    if (tx_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL spurious_txreq: got txreq=1 with txdata %h required 0 at %0t", txdata, $time);
                    end else begin
                        b = tx_q.pop_front();
                        check32("txdata", {24'h0, txdata}, {24'h0, b});
                        check32("txen_at_send", {31'h0, txen_m}, 32'h1);
                    end
                    tx_log.push_back(txdata);
                    held = txdata;
                end else if (txreq) begin
                    check32("txdata_hold", {24'h0, txdata}, {24'h0, held});
                end
                prev_txreq = txreq;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, required finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd;
        bit err;
        bit done;
        rst             = 1'b1;
        rxreq           = 1'b0;
        rxdata          = 8'h00;
        tx_auto         = 1'b1;
        bus_if.armreq   = 1'b0;
        bus_if.armwr    = 1'b0;
        bus_if.armaddr  = 32'h0;
        bus_if.armwdata = 32'h0;
        bus_if.armwstrb = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check32("rst_armack", {31'h0, bus_if.armack}, 32'h0);
        check32("rst_armerr", {31'h0, bus_if.armerr}, 32'h0);
        check32("rst_rdata", bus_if.armrdata, 32'h0);
        check32("rst_txreq", {31'h0, txreq}, 32'h0);
        check32("rst_txdata", {24'h0, txdata}, 32'h0);
        check32("rst_rxack", {31'h0, rxack}, 32'h0);
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);
        check32("status_after_reset", rd, 32'h0000_0006);

        // Transmit two bytes through the handshake
        bus_xfer(1'b1, 32'h0, 32'h41, 4'hF, rd, err);
        bus_xfer(1'b1, 32'h0, 32'h42, 4'hF, rd, err);
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (tx_log.size() == 2 && !txreq) done = 1'b1;
        end
        check32("tx_two_bytes_done", {31'h0, done}, 32'h1);
        if (tx_log.size() == 2) begin
            check32("tx_byte0", {24'h0, tx_log[0]}, 32'h41);
            check32("tx_byte1", {24'h0, tx_log[1]}, 32'h42);
        end
        repeat (2) @(negedge clk);
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);
        check32("status_after_tx", rd, 32'h0000_0006);

        // Strobe-less write is a no-op
        bus_xfer(1'b1, 32'h0, 32'h77, 4'hE, rd, err);
        check32("nostrb_err", {31'h0, err}, 32'h0);

        // Disabled transmitter, fill TX to overflow
        bus_xfer(1'b1, 32'h8, 32'h0, 4'hF, rd, err);
        for (int i = 0; i <= TXD; i++) begin
            bus_xfer(1'b1, 32'h0, 32'h60 + i, 4'hF, rd, err);
            check32("tx_fill_err", {31'h0, err}, (i < TXD) ? 32'h0 : 32'h1);
        end
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);
        check32("tx_full_count", {24'h0, rd[15:8]}, 32'd16);
        check32("tx_full_flag", {31'h0, rd[0]}, 32'h1);
        repeat (4) @(negedge clk);
        check32("txreq_disabled", {31'h0, txreq}, 32'h0);
        bus_xfer(1'b1, 32'h8, 32'h5, 4'hF, rd, err);
        repeat (4) @(negedge clk);
        check32("txreq_after_flush", {31'h0, txreq}, 32'h0);
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);

        // Receive overflow, then drain in order
        for (int i = 0; i <= RXD; i++) rx_send(8'(i));
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);
        check32("rx_overrun", {31'h0, rd[4]}, 32'h1);
        check32("rx_full_count", {24'h0, rd[23:16]}, 32'd16);
        for (int i = 0; i <= RXD; i++) begin
            bus_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, err);
            check32("rx_read", rd, (i < RXD) ? 32'(i) : 32'h8000_0000);
        end
        bus_xfer(1'b1, 32'h8, 32'h2, 4'hF, rd, err);
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);
        check32("overrun_cleared", {31'h0, rd[4]}, 32'h0);
        bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, err);
        check32("ctrl_read", rd, 32'h0);
        bus_xfer(1'b1, 32'h8, 32'h1, 4'hF, rd, err);

        // Unmapped address
        bus_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, err);
        check32("addr3_rd_err", {31'h0, err}, 32'h1);
        check32("addr3_rd_data", rd, 32'h0);
        bus_xfer(1'b1, 32'hC, 32'hFF, 4'hF, rd, err);
        check32("addr3_wr_err", {31'h0, err}, 32'h1);
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);

        // Receive at full with a same-cycle bus pop
        for (int i = 0; i < RXD; i++) rx_send(8'hA0 + 8'(i));
        fork
            bus_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, err);
            rx_drive(8'hEE);
        join
        rx_q.push_back(8'hEE);
        check32("simul_pop", rd, 32'h0000_00A0);
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);
        check32("simul_no_overrun", {31'h0, rd[4]}, 32'h0);
        check32("simul_rx_count", {24'h0, rd[23:16]}, 32'd16);
        for (int i = 0; i < RXD; i++) bus_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, err);
        check32("simul_last", rd, 32'h0000_00EE);

        // Reset while a byte is in flight
        tx_auto = 1'b0;
        bus_xfer(1'b1, 32'h0, 32'h5A, 4'hF, rd, err);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (txreq) done = 1'b1;
        end
        check32("txreq_before_rst", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check32("txreq_after_rst", {31'h0, txreq}, 32'h0);
        tx_auto = 1'b1;
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, err);
        check32("status_after_rst", rd, 32'h0000_0006);

        repeat (3) @(negedge clk);
        check32("pending_acks", 32'(exp_rd_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_ctl.md
Name: uart_ctl

Overview:
- Memory-mapped UART controller between the ARM-side simple bus (from the AXI3 bridge) and the byte-level uart core.
- Buffers transmit and receive bytes in FIFOs and sequences the uart tx handshake.
- Exposes data, status and control registers, so software does not stall the bus on a slow serial line.

Parameters:
TX_DEPTH, 16, transmit FIFO entries; power of 2, 2..128
RX_DEPTH, 16, receive FIFO entries; power of 2, 2..128

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous active-high reset
armaddr  input  32  bus address; only [3:2] decoded
armwdata  input  32  write data
armwstrb  input  4  byte strobes
armwr  input  1  1=write, 0=read; valid while armreq
armreq  input  1  bus request; held until armack
armack  output  1  one-cycle transfer-complete pulse
armerr  output  1  error flag, valid with armack
armrdata  output  32  read data, valid with armack
txreq  output  1  byte ready for uart transmitter
txack  input  1  uart accepted txdata (one-cycle pulse)
txdata  output  8  byte to transmit; stable while txreq
rxreq  input  1  uart holds received byte on rxdata
rxack  output  1  one-cycle pulse: byte consumed
rxdata  input  8  received byte

Behaviour:
- Reset: armack=0, armerr=0, armrdata=0, txreq=0, txdata=0, rxack=0; both FIFOs empty; overrun=0; txen=1; TX FSM in IDLE.
- Bus protocol:
  - armreq seen high while armack=0 → armack=1 on the next cycle, exactly one cycle.
  - armack must not reassert while the same armreq is still held in the ack cycle, so there is one ack per request.
  - armrdata and armerr are valid only in the ack cycle; armrdata=0 otherwise.
- Register map on armaddr[3:2]:
  - 0 DATA
    - Write with armwstrb[0]=1 pushes armwdata[7:0] into the TX FIFO.
    - Write when TX is full → armerr=1, byte dropped.
    - Write with armwstrb[0]=0 → no effect, no error.
    - Read pops the RX FIFO: rdata={24'b0,byte}.
    - Read when RX is empty → rdata=32'h8000_0000, no pop, no error.
  - 1 STATUS, read-only; writes are ignored without error.
    - [0] txfull, [1] txempty, [2] rxempty, [3] rxfull, [4] overrun.
    - [15:8] tx count, [23:16] rx count, zero-extended.
  - 2 CTRL, write:
    - [0] txen.
    - [1]=1 clears overrun.
    - [2]=1 flushes the TX FIFO.
    - [3]=1 flushes the RX FIFO.
  - 2 CTRL, read: {31'b0, txen}.
  - 3: any access → armerr=1, rdata=0, no side effects.
- All register side effects take place in the ack cycle.
- TX FSM:
  - IDLE: if txen and TX FIFO non-empty → pop head into txdata, txreq=1, go SEND.
  - SEND: hold txreq and txdata until txack=1 → txreq=0 on the next cycle, go IDLE.
  - txreq is low for at least one cycle between bytes.
  - Clearing txen or flushing TX does not abort a byte already in SEND; flush empties only the FIFO.
  - txack while in IDLE is ignored.
- RX path:
  - rxreq=1 and rxack not asserted in the previous cycle → rxack=1 for one cycle.
  - Push rxdata if RX count < RX_DEPTH, or if a bus pop occurs in the same cycle.
  - Otherwise discard the byte and set sticky overrun.
  - rxack is sent whether the byte was kept or discarded, so the uart is never stalled.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle leaves the count unchanged and is legal at full and at empty (RX: pop of an empty FIFO is none).
  - Overrun set and clear in the same cycle → set wins.
  - A flush in the same cycle as a push leaves the FIFO empty.
- Pointers wrap modulo depth; counts are log2(DEPTH)+1 bits wide.
- rst mid-transfer drops txreq immediately on the next edge and loses all buffered data.

Test Plan:
- Reset, then read STATUS → armack one cycle after armreq, rdata=32'h0000_0006.
- Write 8'h41, 8'h42 to DATA; txack pulses 3 cycles after each txreq rise → txdata 8'h41 then 8'h42, txreq low at least 1 cycle between them, STATUS ends at 6.
- Clear txen, write TX_DEPTH+1 bytes → first 16 writes armerr=0, 17th armerr=1; STATUS[15:8]=16, [0]=1; txreq stays 0.
- Feed RX_DEPTH+1 bytes via rxreq with no reads → each gets a one-cycle rxack; STATUS[4]=1, rx count=16; DATA reads return bytes 0..15 in order; 17th read returns 32'h8000_0000; CTRL write 2 clears overrun.
- Access address 0xC → armerr=1, rdata=0; then a write pushed the same cycle rxreq arrives while RX is full and a DATA read pops → byte accepted, overrun stays 0.
- Assert rst while txreq=1 in SEND → next cycle txreq=0, STATUS reads 32'h0000_0006 after reset.
